// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: handshake FSM states and default field widths
// for the EX/MEM and MEM/WB stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL2 = 2'd2
  } state_e;

  // EX/MEM: {reg_write, mem_read, mem_write, mem_to_reg}
  localparam int unsigned EXMEM_CTRL_W = 4;
  // EX/MEM: {alu_result, rs2_data, pc_plus4, imm} (32 each) + {rd, rs2} (5 each)
  localparam int unsigned EXMEM_DATA_W = 138;
  // MEM/WB: {reg_write, mem_to_reg}
  localparam int unsigned MEMWB_CTRL_W = 2;
  // MEM/WB: {alu_result, read_data, pc_plus4} (32 each) + rd (5)
  localparam int unsigned MEMWB_DATA_W = 101;

endpackage

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline-stage register with flush, bubble-zeroed control field
// and an optional two-entry skid buffer that keeps in_ready off the combinational path.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W     = EXMEM_CTRL_W,
  parameter int unsigned DATA_W     = EXMEM_DATA_W,
  parameter bit          SKID       = 1'b1,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              accept;
  logic              consume;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;

  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;
  assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};
  assign out_data = main_data;

  if (SKID) begin : g_skid
    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;

    always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
        state_d     = ST_EMPTY;
        main_ctrl_d = '0;
        skid_ctrl_d = '0;
        if (CLEAR_DATA) begin
          main_data_d = '0;
          skid_data_d = '0;
        end
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              state_d     = ST_ONE;
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
            end
          end
          ST_ONE: begin
            if (accept && consume) begin
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
            end else if (consume) begin
              state_d     = ST_EMPTY;
              main_ctrl_d = '0;
              if (CLEAR_DATA) main_data_d = '0;
            end else if (accept) begin
              state_d     = ST_FULL2;
              skid_ctrl_d = in_ctrl;
              skid_data_d = in_data;
            end
          end
          ST_FULL2: begin
            if (consume) begin
              state_d     = ST_ONE;
              main_ctrl_d = skid_ctrl_q;
              main_data_d = skid_data_q;
              skid_ctrl_d = '0;
              if (CLEAR_DATA) skid_data_d = '0;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
      // Ready is decided from the next state so it can be registered.
      in_ready_d = (state_d != ST_FULL2);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q     <= ST_EMPTY;
        in_ready_q  <= 1'b1;
        main_ctrl_q <= '0;
        main_data_q <= '0;
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
      end else begin
        state_q     <= state_d;
        in_ready_q  <= in_ready_d;
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        skid_data_q <= skid_data_d;
      end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign main_ctrl = main_ctrl_q;
    assign main_data = main_data_q;

  end else begin : g_single
    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;

    always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      if (flush) begin
        state_d     = ST_EMPTY;
        main_ctrl_d = '0;
        if (CLEAR_DATA) main_data_d = '0;
      end else if (accept) begin
        state_d     = ST_ONE;
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else if (consume) begin
        state_d     = ST_EMPTY;
        main_ctrl_d = '0;
        if (CLEAR_DATA) main_data_d = '0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q     <= ST_EMPTY;
        main_ctrl_q <= '0;
        main_data_q <= '0;
      end else begin
        state_q     <= state_d;
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
      end
    end

    assign out_valid = (state_q == ST_ONE);
    assign in_ready  = out_ready | ~out_valid;
    assign main_ctrl = main_ctrl_q;
    assign main_data = main_data_q;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: three variants (skid/clear, skid/hold, single/clear)
// share one stimulus stream; each accepted entry is queued and popped on consume.
module tb_pipe_stage_skid;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 138;
  localparam int unsigned EW = CW + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [CW-1:0] a_out_ctrl, b_out_ctrl, c_out_ctrl;
  logic [DW-1:0] a_out_data, b_out_data, c_out_data;

  int n_pass  = 0;
  int n_total = 0;
  logic [EW-1:0] sb_a[$];
  logic [EW-1:0] sb_c[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CLEAR_DATA(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data));

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CLEAR_DATA(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data));

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CLEAR_DATA(1'b1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_ctrl(c_out_ctrl), .out_data(c_out_data));

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected-response producer: every accepted entry is owed at the output, in order.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb_a.delete();
      sb_c.delete();
    end else begin
      if (in_valid && a_in_ready) sb_a.push_back({in_ctrl, in_data});
      if (in_valid && c_in_ready) sb_c.push_back({in_ctrl, in_data});
    end
  end

  // Monitor: compare on every consume, and police the bubble control field.
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (a_out_valid && out_ready) begin
        if (sb_a.size() == 0) begin
          n_total++;
          $display("FAIL a_unexpected: emitted %0h, required no entry", {a_out_ctrl, a_out_data});
        end else chk("a_sb_out", {a_out_ctrl, a_out_data}, sb_a.pop_front());
      end
      if (c_out_valid && out_ready) begin
        if (sb_c.size() == 0) begin
          n_total++;
          $display("FAIL c_unexpected: emitted %0h, required no entry", {c_out_ctrl, c_out_data});
        end else chk("c_sb_out", {c_out_ctrl, c_out_data}, sb_c.pop_front());
      end
      if (!a_out_valid) chk("a_bubble_ctrl", a_out_ctrl, '0);
      if (!b_out_valid) chk("b_bubble_ctrl", b_out_ctrl, '0);
      if (!c_out_valid) chk("c_bubble_ctrl", c_out_ctrl, '0);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_valid", a_out_valid, 0);
    chk("rst_ctrl", a_out_ctrl, 0);
    chk("rst_data", a_out_data, 0);
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", a_in_ready, 1);

    // Back-to-back streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc(); in_valid = 1'b1; in_ctrl = 4'hF; in_data = DW'(i);
      @(negedge clk);
      chk("stream_in_ready", a_in_ready, 1);
      chk("stream_c_in_ready", c_in_ready, 1);
      if (i > 1) chk("stream_out", {a_out_ctrl, a_out_data}, {4'hF, DW'(i - 1)});
    end
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", {a_out_ctrl, a_out_data}, {4'hF, DW'(8)});
    cyc();
    @(negedge clk);
    chk("drain_valid", a_out_valid, 0);
    chk("drain_data_clr", a_out_data, 0);
    chk("b_drain_data_hold", b_out_data, DW'(8));

    // Stall with skid fill
    cyc(); in_valid = 1'b1; in_ctrl = 4'h3; in_data = DW'(32'hA); out_ready = 1'b1;
    @(negedge clk); chk("stall_ready_a", a_in_ready, 1);
    cyc(); in_ctrl = 4'h5; in_data = DW'(32'hB); out_ready = 1'b0;
    @(negedge clk);
    chk("stall_ready_b", a_in_ready, 1);
    chk("c_ready_stall", c_in_ready, 0);
    cyc(); in_ctrl = 4'h7; in_data = DW'(32'hCC);
    @(negedge clk);
    chk("stall_ready_full", a_in_ready, 0);
    chk("stall_hold1", {a_out_valid, a_out_ctrl, a_out_data}, {1'b1, 4'h3, DW'(32'hA)});
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("stall_hold2", {a_out_ctrl, a_out_data}, {4'h3, DW'(32'hA)});
    chk("c_ready_held", c_in_ready, 0);
    cyc(); out_ready = 1'b1;
    @(negedge clk);
    chk("stall_out_a", {a_out_ctrl, a_out_data}, {4'h3, DW'(32'hA)});
    chk("c_ready_comb", c_in_ready, 1);
    cyc();
    @(negedge clk);
    chk("stall_out_b", {a_out_ctrl, a_out_data}, {4'h5, DW'(32'hB)});
    chk("stall_ready_back", a_in_ready, 1);
    cyc();
    @(negedge clk);
    chk("stall_empty", a_out_valid, 0);

    // Asynchronous reset while FULL2
    cyc(); in_valid = 1'b1; in_ctrl = 4'h9; in_data = DW'(32'h11); out_ready = 1'b0;
    cyc(); in_ctrl = 4'hA; in_data = DW'(32'h22);
    cyc(); in_valid = 1'b0;
    @(negedge clk); chk("pre_rst_full", a_in_ready, 0);
    cyc(); #2 reset = 1'b1; #1;
    chk("midrst_valid", a_out_valid, 0);
    chk("midrst_ctrl", a_out_ctrl, 0);
    chk("midrst_data", a_out_data, 0);
    chk("midrst_c_valid", c_out_valid, 0);
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk("postrst_ready", a_in_ready, 1);
    chk("postrst_valid", a_out_valid, 0);

    // Flush while FULL2 with a new entry offered
    cyc(); in_valid = 1'b1; in_ctrl = 4'hF; in_data = DW'(32'h33); out_ready = 1'b0;
    cyc(); in_data = DW'(32'h44);
    cyc(); flush = 1'b1; in_data = DW'(32'hCC);
    @(negedge clk); chk("flush_full_ready", a_in_ready, 0);
    cyc(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_valid", a_out_valid, 0);
    chk("flush_ctrl", a_out_ctrl, 0);
    chk("flush_ready", a_in_ready, 1);
    cyc();
    @(negedge clk); chk("flush_valid2", a_out_valid, 0);

    // Flush while ONE with an entry that would be accepted
    cyc(); in_valid = 1'b1; in_ctrl = 4'hF; in_data = DW'(32'h55); out_ready = 1'b0;
    cyc(); flush = 1'b1; in_data = DW'(32'hDD);
    @(negedge clk); chk("flush_one_ready", a_in_ready, 1);
    cyc(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_one_valid", a_out_valid, 0);
    chk("flush_one_data", a_out_data, 0);

    // Bubbles with live-looking control on the input
    cyc(); in_valid = 1'b1; in_ctrl = 4'hF; in_data = DW'(32'h5A);
    cyc(); in_valid = 1'b0; in_data = '1;
    @(negedge clk); chk("bubble_src", {a_out_ctrl, a_out_data}, {4'hF, DW'(32'h5A)});
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("bubble_a_ctrl", a_out_ctrl, 0);
      chk("bubble_a_data", a_out_data, 0);
      chk("bubble_b_ctrl", b_out_ctrl, 0);
      chk("bubble_b_data", b_out_data, DW'(32'h5A));
    end

    // Random valid/ready traffic against the scoreboards
    for (int i = 0; i < 300; i++) begin
      cyc();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_ctrl   = 4'($urandom);
      in_data   = DW'(1000 + i);
    end
    cyc(); in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    chk("a_sb_drained", EW'(sb_a.size()), 0);
    chk("c_sb_drained", EW'(sb_c.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
